// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiplies by shift-add and divides by restoring division on operand
// magnitudes, retiring RADIX_BITS bits per CALC cycle, then fixes the sign
// and selects the requested half in a single FIX cycle. The pipeline is held
// through the stall output until the one-cycle done pulse.
module ex_muldiv_unit #(
    parameter int DATA_W     = 32,
    parameter int RADIX_BITS = 1,
    parameter int RF_ADDRESS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            func3,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    input  logic [RF_ADDRESS-1:0] rd_in,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     result,
    output logic [RF_ADDRESS-1:0] rd_out
);

    localparam int ITER  = DATA_W / RADIX_BITS;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       acc_q, acc_d;     // product high half / partial remainder
    logic [DATA_W-1:0]       lo_q, lo_d;       // multiplier -> product low half / dividend -> quotient
    logic [DATA_W-1:0]       opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [2:0]              f3_q, f3_d;
    logic                    negp_q, negp_d;   // negate product or quotient
    logic                    negr_q, negr_d;   // negate remainder
    logic [DATA_W-1:0]       result_q, result_d;
    logic [RF_ADDRESS-1:0]   rd_q, rd_d;

    // Magnitude of a value, treating it as two's complement only when sgn is set.
    // The most negative value maps to 2^(DATA_W-1), which still fits unsigned.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
    endfunction

    // Operand decode for the request currently on the inputs
    logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic              div_zero, div_ovf, special, accept;
    logic [DATA_W-1:0] special_val;

    assign is_div   = func3[2];
    assign a_sgn    = is_div ? ~func3[0] : (func3 == 3'b001 || func3 == 3'b010);
    assign b_sgn    = is_div ? ~func3[0] : (func3 == 3'b001);
    assign a_neg    = a_sgn & op_a[DATA_W-1];
    assign b_neg    = b_sgn & op_b[DATA_W-1];
    assign div_zero = is_div && (op_b == '0);
    assign div_ovf  = is_div && !func3[0] && (op_a == MIN_NEG) && (op_b == '1);
    assign special  = div_zero | div_ovf;
    // Divide by zero: quotient all-ones, remainder = dividend.
    // Signed overflow: quotient = dividend, remainder = 0.
    assign special_val = div_zero ? (func3[1] ? op_a : '1)
                                  : (func3[1] ? '0 : op_a);
    assign accept   = (state_q == S_IDLE) && start && !flush;

    // One CALC iteration: RADIX_BITS unrolled shift-add or restoring-divide steps
    logic [DATA_W-1:0] it_acc, it_lo;
    logic [DATA_W:0]   dtmp, msum;
    always_comb begin
        it_acc = acc_q;
        it_lo  = lo_q;
        dtmp   = '0;
        msum   = '0;
        for (int k = 0; k < RADIX_BITS; k++) begin
            if (f3_q[2]) begin
                dtmp  = {it_acc, it_lo[DATA_W-1]};
                it_lo = {it_lo[DATA_W-2:0], 1'b0};
                if (dtmp >= {1'b0, opnd_q}) begin
                    dtmp     = dtmp - {1'b0, opnd_q};
                    it_lo[0] = 1'b1;
                end
                it_acc = dtmp[DATA_W-1:0];
            end else begin
                msum   = {1'b0, it_acc} + (it_lo[0] ? {1'b0, opnd_q} : '0);
                it_lo  = {msum[0], it_lo[DATA_W-1:1]};
                it_acc = msum[DATA_W:1];
            end
        end
    end

    // FIX: sign correction and half/quotient/remainder selection
    logic [2*DATA_W-1:0] prod, prod_s;
    logic [DATA_W-1:0]   quo_s, rem_s, fix_val;
    always_comb begin
        prod   = {acc_q, lo_q};
        prod_s = negp_q ? (~prod + 1'b1) : prod;
        quo_s  = negp_q ? (~lo_q + 1'b1) : lo_q;
        rem_s  = negr_q ? (~acc_q + 1'b1) : acc_q;
        if (f3_q[2]) begin
            fix_val = f3_q[1] ? rem_s : quo_s;
        end else if (f3_q == 3'b000) begin
            fix_val = prod_s[DATA_W-1:0];
        end else begin
            fix_val = prod_s[2*DATA_W-1:DATA_W];
        end
    end

    // FSM next state, iteration counter and handshake outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = (state_q != S_IDLE);
        stall   = accept || (state_q == S_CALC) || (state_q == S_FIX);
        done    = (state_q == S_DONE) && !flush;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Datapath next state: latch operands on accept, iterate in CALC, commit in FIX
    always_comb begin
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        f3_d     = f3_q;
        negp_d   = negp_q;
        negr_d   = negr_q;
        result_d = result_q;
        rd_d     = rd_q;
        if (accept) begin
            f3_d   = func3;
            rd_d   = rd_in;
            acc_d  = '0;
            lo_d   = mag(op_a, a_sgn);
            opnd_d = mag(op_b, b_sgn);
            negp_d = a_neg ^ b_neg;
            negr_d = a_neg;
            if (special) begin
                result_d = special_val;
            end
        end else if (state_q == S_CALC && !flush) begin
            acc_d = it_acc;
            lo_d  = it_lo;
        end else if (state_q == S_FIX && !flush) begin
            result_d = fix_val;
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            f3_q     <= '0;
            negp_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            f3_q     <= f3_d;
            negp_q   <= negp_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: a radix-2 (1 bit/cycle) and a
// 4 bits/cycle instance share the same stimulus; expected results, rd and
// latency are queued per instance at issue and checked on each done pulse.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  func3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;

    logic        stall1, busy1, done1;
    logic [31:0] result1;
    logic [4:0]  rd_out1;
    logic        stall4, busy4, done4;
    logic [31:0] result4;
    logic [4:0]  rd_out4;

    ex_muldiv_unit #(.DATA_W(32), .RADIX_BITS(1), .RF_ADDRESS(5)) u_r1 (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .func3(func3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall(stall1), .busy(busy1),
        .done(done1), .result(result1), .rd_out(rd_out1));

    ex_muldiv_unit #(.DATA_W(32), .RADIX_BITS(4), .RF_ADDRESS(5)) u_r4 (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .func3(func3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall(stall4), .busy(busy4),
        .done(done4), .result(result4), .rd_out(rd_out4));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        longint      acc;
    } exp_t;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        logic        sp;
    } vec_t;

    exp_t   q1[$];
    exp_t   q4[$];
    int     nchk = 0;
    int     nerr = 0;
    longint cyc = 0;
    int     st1 = 0;
    int     st4 = 0;
    bit     mon_en = 1'b0;
    vec_t   vecs [0:20];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic mon(input int w, input logic [31:0] res, input logic [4:0] rd, input logic stl);
        exp_t  e;
        string tag;
        int    pend;
        int    stc;
        tag  = (w == 1) ? "r1" : "r4";
        pend = (w == 1) ? q1.size() : q4.size();
        stc  = (w == 1) ? st1 : st4;
        if (pend == 0) begin
            nchk++;
            nerr++;
            $display("FAIL %s_unexpected_done: got done=1 result=0x%0h expected no done", tag, res);
        end else begin
            if (w == 1) e = q1.pop_front();
            else        e = q4.pop_front();
            chk($sformatf("%s_result", tag), res, e.res);
            chk($sformatf("%s_rd_out", tag), rd, e.rd);
            chk($sformatf("%s_latency", tag), cyc - e.acc + 1, e.lat);
            chk($sformatf("%s_stall_cycles", tag), stc, e.lat - 1);
            chk($sformatf("%s_stall_at_done", tag), stl, 0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall1) st1++;
            if (stall4) st4++;
            if (done1) mon(1, result1, rd_out1, stall1);
            if (done4) mon(4, result4, rd_out4, stall4);
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit sp, input bit push);
        exp_t e;
        @(negedge clk);
        func3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        #1;
        if (push) begin
            chk("r1_stall_on_start", stall1, 1);
            chk("r4_stall_on_start", stall4, 1);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = ~a ^ 32'h5a5a_0f0f;
        op_b  = b + 32'd3;
        func3 = ~f;
        rd_in = ~rd;
        st1 = 0;
        st4 = 0;
        if (push) begin
            e.res = exp; e.rd = rd; e.acc = cyc;
            e.lat = sp ? 1 : 34;
            q1.push_back(e);
            e.lat = sp ? 1 : 10;
            q4.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        nchk++;
        if (q1.size() != 0 || q4.size() != 0) begin
            nerr++;
            $display("FAIL drain_timeout: pending r1=%0d r4=%0d expected 0", q1.size(), q4.size());
            q1.delete();
            q4.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{
            '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0},
            '{3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 1'b0},
            '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 1'b0},
            '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h7FFF_FFFF, 1'b0},
            '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFE, 1'b0},
            '{3'b000, 32'h0000_0000, 32'h1234_5678, 5'd10, 32'h0000_0000, 1'b0},
            '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFD, 1'b0},
            '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFF, 1'b0},
            '{3'b101, 32'd100,       32'd7,         5'd13, 32'd14,        1'b0},
            '{3'b111, 32'd100,       32'd7,         5'd14, 32'd2,         1'b0},
            '{3'b100, 32'd20,        32'hFFFF_FFFA, 5'd15, 32'hFFFF_FFFD, 1'b0},
            '{3'b110, 32'd20,        32'hFFFF_FFFA, 5'd16, 32'd2,         1'b0},
            '{3'b101, 32'hFFFF_FFFF, 32'd1,         5'd17, 32'hFFFF_FFFF, 1'b0},
            '{3'b100, 32'd1234,      32'd0,         5'd18, 32'hFFFF_FFFF, 1'b1},
            '{3'b111, 32'd5,         32'd0,         5'd19, 32'd5,         1'b1},
            '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1'b1},
            '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h0000_0000, 1'b1},
            '{3'b101, 32'd9,         32'd0,         5'd22, 32'hFFFF_FFFF, 1'b1},
            '{3'b110, 32'hFFFF_FFF9, 32'd0,         5'd23, 32'hFFFF_FFF9, 1'b1},
            '{3'b000, 32'h0001_2345, 32'h0000_0100, 5'd24, 32'h0123_4500, 1'b0},
            '{3'b001, 32'hFFFF_FFFE, 32'd3,         5'd25, 32'hFFFF_FFFF, 1'b0}
        };
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        func3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("r1_reset_outputs", {stall1, busy1, done1, rd_out1, result1}, 0);
        chk("r4_reset_outputs", {stall4, busy4, done4, rd_out4, result4}, 0);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 21; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].sp, 1'b1);
            drain();
        end

        // a second start while busy must be ignored
        issue(3'b101, 32'd100, 32'd7, 5'd26, 32'd14, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        func3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd27; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (40) @(posedge clk);

        // flush in CALC aborts without done and keeps the old result
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd28, 32'd0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("r1_flush_busy", busy1, 0);
        chk("r1_flush_stall", stall1, 0);
        chk("r4_flush_busy", busy4, 0);
        chk("r4_flush_stall", stall4, 0);
        chk("r1_flush_result_kept", result1, 32'd14);
        repeat (40) @(posedge clk);
        #1;
        chk("r1_flush_result_still_kept", result1, 32'd14);
        chk("r4_flush_result_still_kept", result4, 32'd14);

        // start together with flush in IDLE is ignored
        @(negedge clk);
        func3 = 3'b101; op_a = 32'd9; op_b = 32'd0; rd_in = 5'd3; start = 1'b1; flush = 1'b1;
        #1;
        chk("r1_flush_start_stall", stall1, 0);
        chk("r4_flush_start_stall", stall4, 0);
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("r1_flush_start_busy", busy1, 0);
        chk("r4_flush_start_busy", busy4, 0);
        repeat (5) @(posedge clk);

        // asynchronous reset in the middle of CALC
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd29, 32'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("r1_midcalc_reset_outputs", {stall1, busy1, done1, rd_out1, result1}, 0);
        chk("r4_midcalc_reset_outputs", {stall4, busy4, done4, rd_out4, result4}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("r1_after_reset_idle", {busy1, result1}, 0);
        chk("r4_after_reset_idle", {busy4, result4}, 0);

        issue(3'b101, 32'd100, 32'd7, 5'd30, 32'd14, 1'b0, 1'b1);
        drain();
        repeat (40) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
